// File: rtl/seq_detector_param.sv
// seq_detector_param
//
// Purpose:
//   Watches a stream of DATA_W-bit symbols for a runtime-programmable
//   pattern of SEQ_LEN symbols. Each pattern position can be marked
//   don't-care. Overlapping or restart-after-match behaviour is selected
//   by overlap_en. A match produces a registered one-cycle pulse and
//   bumps a saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active-high (1 = reset asserted)
//   data_valid   data carries a new symbol this cycle
//   data         input symbol
//   overlap_en   1 = overlapping matches, 0 = restart search after a match
//   cfg_we       pattern write strobe (wins over data_valid)
//   cfg_idx      pattern position to write
//   cfg_sym      symbol value for cfg_idx
//   cfg_care     0 = position cfg_idx is don't-care
//   seq_found    one-cycle match pulse, one cycle after the accepting edge
//   match_count  matches since reset, saturating at all-ones
//   hist_fill    number of valid symbols held in the history window
module seq_detector_param #(
  parameter int DATA_W = 3,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W = 16,
  parameter logic [SEQ_LEN*DATA_W-1:0] PATTERN_INIT = {3'b111, 3'b110, 3'b101, 3'b001},
  parameter int IDX_W = $clog2(SEQ_LEN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         data_valid,
  input  logic [DATA_W-1:0]            data,
  input  logic                         overlap_en,
  input  logic                         cfg_we,
  input  logic [IDX_W-1:0]             cfg_idx,
  input  logic [DATA_W-1:0]            cfg_sym,
  input  logic                         cfg_care,
  output logic                         seq_found,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(SEQ_LEN+1)-1:0] hist_fill
);

  localparam int FILL_W = $clog2(SEQ_LEN + 1);
  localparam int HIST_W = (SEQ_LEN - 1) * DATA_W;
  localparam int WIN_W  = SEQ_LEN * DATA_W;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(SEQ_LEN - 1);
  localparam logic [IDX_W:0]    IDX_LIMIT = (IDX_W + 1)'(SEQ_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Only the SEQ_LEN-1 previous symbols are stored; the incoming symbol
  // completes the window. Slot 0 of hist is the oldest symbol.
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               found_q, found_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIN_W-1:0]   pattern_q, pattern_d;
  logic [SEQ_LEN-1:0] care_q, care_d;

  logic [WIN_W-1:0]   window;
  logic               pattern_hit;
  logic               accept;
  logic               cfg_write;
  logic               match;

  // The window is history with the incoming symbol appended at the top,
  // so window position i lines up with pattern symbol i.
  assign window = {data, hist_q};

  // Compare every cared-about position; don't-care positions always pass,
  // so an all-don't-care pattern matches any full window.
  always_comb begin
    pattern_hit = 1'b1;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (care_q[i] && (window[i*DATA_W +: DATA_W] != pattern_q[i*DATA_W +: DATA_W])) begin
        pattern_hit = 1'b0;
      end
    end
  end

  // A config strobe blocks symbol acceptance even when its index is out of
  // range; only in-range indices actually write and flush.
  assign accept    = data_valid & ~cfg_we;
  assign cfg_write = cfg_we & ({1'b0, cfg_idx} < IDX_LIMIT);
  assign match     = accept && (fill_q >= FILL_NEED) && pattern_hit;

  // Next-state logic for history, fill level, pattern store and counter.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    care_d    = care_q;
    found_d   = match;
    count_d   = count_q;

    if (cfg_write) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          pattern_d[i*DATA_W +: DATA_W] = cfg_sym;
          care_d[i]                     = cfg_care;
        end
      end
      // Old history was collected against the old pattern, so drop it.
      fill_d = '0;
    end else if (accept) begin
      hist_d = window[WIN_W-1:DATA_W];
      if (match && !overlap_en) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (match && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      found_q   <= 1'b0;
      count_q   <= '0;
      pattern_q <= PATTERN_INIT;
      care_q    <= '1;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      found_q   <= found_d;
      count_q   <= count_d;
      pattern_q <= pattern_d;
      care_q    <= care_d;
    end
  end

  assign seq_found   = found_q;
  assign match_count = count_q;
  assign hist_fill   = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param. A default-parameter instance is the
// main target; a second instance with a 2-bit counter shares the same
// stimulus so counter saturation can be observed quickly.
module tb_seq_detector_param;

  logic       clk;
  logic       rst_n;
  logic       data_valid;
  logic [2:0] data;
  logic       overlap_en;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [2:0] cfg_sym;
  logic       cfg_care;

  logic        seq_found;
  logic [15:0] match_count;
  logic [2:0]  hist_fill;

  logic        sat_found;
  logic [1:0]  sat_count;
  logic [2:0]  sat_fill;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [2:0]  data;
    logic        ovl;
    logic        we;
    logic [1:0]  idx;
    logic [2:0]  sym;
    logic        care;
    logic        exp_found;
    logic [2:0]  exp_fill;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tbl[$];

  seq_detector_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_valid  (data_valid),
    .data        (data),
    .overlap_en  (overlap_en),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_sym     (cfg_sym),
    .cfg_care    (cfg_care),
    .seq_found   (seq_found),
    .match_count (match_count),
    .hist_fill   (hist_fill)
  );

  seq_detector_param #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_valid  (data_valid),
    .data        (data),
    .overlap_en  (overlap_en),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_sym     (cfg_sym),
    .cfg_care    (cfg_care),
    .seq_found   (sat_found),
    .match_count (sat_count),
    .hist_fill   (sat_fill)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] d, input logic o,
                              input logic we, input logic [1:0] idx, input logic [2:0] sym,
                              input logic care, input logic ef, input logic [2:0] efill,
                              input logic [15:0] ecnt);
    vec_t r;
    r.valid = v;  r.data = d;  r.ovl = o;  r.we = we;  r.idx = idx;
    r.sym = sym;  r.care = care;
    r.exp_found = ef;  r.exp_fill = efill;  r.exp_count = ecnt;
    return r;
  endfunction

  // Drive one cycle of inputs on the falling edge, then sample 1 unit after
  // the following rising edge, where the registered outputs have settled.
  task automatic applyStimulus(input logic v, input logic [2:0] d, input logic o,
                               input logic we, input logic [1:0] idx,
                               input logic [2:0] sym, input logic care);
    @(negedge clk);
    data_valid = v;  data = d;  overlap_en = o;
    cfg_we = we;  cfg_idx = idx;  cfg_sym = sym;  cfg_care = care;
    @(posedge clk);
    #1;
  endtask

  task automatic sendSym(input logic [2:0] d, input logic o);
    applyStimulus(1'b1, d, o, 1'b0, 2'd0, 3'd0, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, overlap_en, 1'b0, 2'd0, 3'd0, 1'b1);
  endtask

  task automatic writeCfg(input logic [1:0] idx, input logic [2:0] sym, input logic care);
    applyStimulus(1'b0, 3'd0, overlap_en, 1'b1, idx, sym, care);
  endtask

  // Asynchronous reset pulse placed strictly between clock edges.
  task automatic doReset();
    @(negedge clk);
    data_valid = 1'b0;  cfg_we = 1'b0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic ef, input logic [2:0] efill,
                             input logic [15:0] ecnt);
    checks++;
    if (seq_found !== ef) begin
      errors++;
      $display("[TB] FAIL %s.seq_found: got %0b expected %0b", name, seq_found, ef);
    end
    checks++;
    if (hist_fill !== efill) begin
      errors++;
      $display("[TB] FAIL %s.hist_fill: got %0d expected %0d", name, hist_fill, efill);
    end
    checks++;
    if (match_count !== ecnt) begin
      errors++;
      $display("[TB] FAIL %s.match_count: got %0d expected %0d", name, match_count, ecnt);
    end
  endtask

  task automatic checkSat(input string name, input logic [1:0] ecnt);
    checks++;
    if (sat_count !== ecnt) begin
      errors++;
      $display("[TB] FAIL %s.sat_count: got %0d expected %0d", name, sat_count, ecnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;  data_valid = 1'b0;  data = 3'd0;  overlap_en = 1'b0;
    cfg_we = 1'b0;  cfg_idx = 2'd0;  cfg_sym = 3'd0;  cfg_care = 1'b1;

    // Table: default pattern detection, then overlap / non-overlap runs.
    tbl.push_back(mk(1, 3'b001, 0, 0, 0, 0, 1, 0, 3'd1, 16'd0));
    tbl.push_back(mk(1, 3'b101, 0, 0, 0, 0, 1, 0, 3'd2, 16'd0));
    tbl.push_back(mk(1, 3'b110, 0, 0, 0, 0, 1, 0, 3'd3, 16'd0));
    tbl.push_back(mk(1, 3'b111, 0, 0, 0, 0, 1, 1, 3'd0, 16'd1));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, 3'b111, 0, 0, 0, 0, 1, 0, 3'((k + 1 > 4) ? 4 : k + 1), 16'd1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 3'b000, 1, 1, 2'(k), 3'b001, 1, 0, 3'd0, 16'd1));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1, 3'b001, 1, 0, 0, 0, 1, (k >= 3), 3'((k + 1 > 4) ? 4 : k + 1),
                       16'(1 + ((k > 2) ? k - 2 : 0))));
    tbl.push_back(mk(0, 3'b000, 0, 1, 2'd0, 3'b001, 1, 0, 3'd0, 16'd4));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 3'b001, 0, 0, 0, 0, 1, (k % 4 == 3), 3'((k % 4 == 3) ? 0 : k % 4 + 1),
                       16'(4 + ((k >= 3) ? 1 : 0) + ((k >= 7) ? 1 : 0))));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 0, 3'd0, 16'd6));

    // Reset state.
    doReset();
    #1;
    checkOutput("reset", 1'b0, 3'd0, 16'd0);
    checkSat("reset", 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].valid, tbl[i].data, tbl[i].ovl, tbl[i].we, tbl[i].idx,
                    tbl[i].sym, tbl[i].care);
      checkOutput($sformatf("vec%0d", i), tbl[i].exp_found, tbl[i].exp_fill, tbl[i].exp_count);
    end

    // Bubbles between symbols do not break the sequence.
    doReset();
    sendSym(3'b001, 0);  idle();  idle();
    sendSym(3'b101, 0);  idle();  idle();
    sendSym(3'b110, 0);  idle();  idle();
    checkOutput("gap_pre", 1'b0, 3'd3, 16'd0);
    sendSym(3'b111, 0);
    checkOutput("gap_hit", 1'b1, 3'd0, 16'd1);
    idle();
    checkOutput("gap_drop", 1'b0, 3'd0, 16'd1);

    // Don't-care on position 2.
    writeCfg(2'd2, 3'b110, 1'b0);
    checkOutput("dc_cfg", 1'b0, 3'd0, 16'd1);
    sendSym(3'b001, 0);  sendSym(3'b101, 0);  sendSym(3'b000, 0);
    checkOutput("dc_pre", 1'b0, 3'd3, 16'd1);
    sendSym(3'b111, 0);
    checkOutput("dc_hit", 1'b1, 3'd0, 16'd2);

    // Config write in the same cycle as a valid symbol: config wins.
    sendSym(3'b001, 0);  sendSym(3'b101, 0);  sendSym(3'b110, 0);
    checkOutput("mid_pre", 1'b0, 3'd3, 16'd2);
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b1, 2'd3, 3'b111, 1'b1);
    checkOutput("mid_cfg", 1'b0, 3'd0, 16'd2);
    sendSym(3'b111, 0);
    checkOutput("mid_after", 1'b0, 3'd1, 16'd2);

    // Saturation on the 2-bit counter instance.
    doReset();
    for (int m = 0; m < 4; m++) begin
      sendSym(3'b001, 0);  sendSym(3'b101, 0);  sendSym(3'b110, 0);  sendSym(3'b111, 0);
    end
    checkOutput("sat4", 1'b1, 3'd0, 16'd4);
    checkSat("sat4", 2'd3);
    idle();  idle();
    checkSat("sat_hold", 2'd3);

    // Alter pattern then get a fifth match with overlap on.
    writeCfg(2'd0, 3'b010, 1'b1);
    sendSym(3'b010, 1);  sendSym(3'b101, 1);  sendSym(3'b110, 1);  sendSym(3'b111, 1);
    checkOutput("sat5", 1'b1, 3'd4, 16'd5);
    checkSat("sat5", 2'd3);

    // Asynchronous reset between edges while outputs are non-zero.
    rst_n = 1'b1;
    #2;
    checkOutput("async_rst", 1'b0, 3'd0, 16'd0);
    checkSat("async_rst", 2'd0);
    rst_n = 1'b0;

    // Pattern position 0 must be back to its reset value 001.
    sendSym(3'b001, 0);  sendSym(3'b101, 0);  sendSym(3'b110, 0);  sendSym(3'b111, 0);
    checkOutput("pat_restore", 1'b1, 3'd0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised successor to the fixed 3-bit sequence detector. It watches a stream of DATA_W-bit symbols for a runtime-programmable pattern of SEQ_LEN symbols. Each pattern position has a per-position don't-care bit, and overlap or non-overlap matching is selectable. It sits between the symbol source and control logic, and reports a one-cycle match pulse plus a saturating match counter.

Parameters:
DATA_W, 3, symbol width in bits
SEQ_LEN, 4, pattern length in symbols (>=2)
CNT_W, 16, match counter width
PATTERN_INIT, {3'b111,3'b110,3'b101,3'b001}, reset pattern; symbol i at bits [i*DATA_W +: DATA_W], symbol 0 expected first
IDX_W, $clog2(SEQ_LEN), config index width (derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-high (1 = reset asserted)
data_valid  in  1  data carries a new symbol this cycle
data  in  DATA_W  input symbol
overlap_en  in  1  1 = overlapping matches allowed, 0 = restart search after a match
cfg_we  in  1  pattern write strobe
cfg_idx  in  IDX_W  pattern position to write
cfg_sym  in  DATA_W  symbol value for cfg_idx
cfg_care  in  1  0 = position cfg_idx is don't-care
seq_found  out  1  one-cycle match pulse
match_count  out  CNT_W  matches since reset, saturating
hist_fill  out  $clog2(SEQ_LEN+1)  valid symbols held in the history window

Behaviour:
- Reset (rst_n=1, asynchronous):
  - history cleared; hist_fill=0; seq_found=0; match_count=0.
  - pattern=PATTERN_INIT; all care bits=1.
  - Takes effect immediately, without waiting for a clock edge.
- Symbol accept: on a rising edge with data_valid=1 and cfg_we=0.
  - History shifts by one; data becomes the newest entry.
  - hist_fill increments, saturating at SEQ_LEN.
- Match condition: evaluated on the window that includes the incoming symbol.
  - (hist_fill+1) >= SEQ_LEN, and
  - for every position i with care[i]=1, window symbol i equals pattern symbol i. Position 0 is the oldest symbol; position SEQ_LEN-1 is the incoming symbol.
- On match:
  - seq_found=1 in the cycle after the accepting edge (registered, latency 1, exactly one cycle wide).
  - match_count increments, holding at all-ones.
- Overlap handling:
  - overlap_en=1: hist_fill stays at SEQ_LEN, so every subsequent accepted symbol can complete a new match.
  - overlap_en=0: hist_fill is cleared to 0 on a match; the next match needs SEQ_LEN fresh symbols.
  - overlap_en is sampled at the match edge.
- data_valid=0: history, hist_fill and count are unchanged; seq_found=0 in the following cycle. Gaps between symbols do not break a sequence.
- Config write (cfg_we=1, cfg_idx < SEQ_LEN):
  - pattern[cfg_idx] <= cfg_sym; care[cfg_idx] <= cfg_care.
  - History is flushed (hist_fill=0).
  - Any data_valid in the same cycle is dropped; the config write wins.
  - match_count is not changed.
- cfg_we=1 with cfg_idx >= SEQ_LEN: ignored entirely. No write and no flush; a simultaneous data_valid is also dropped.
- All care bits 0: any SEQ_LEN-symbol window matches.
- No combinational path from inputs to outputs.

Test Plan:
- Default config: reset, then stream 001,101,110,111 with data_valid=1 each cycle. Required: seq_found pulses for 1 cycle, one edge after 111 is accepted; match_count=1. Holding data=111 for 10 more cycles gives no further pulse.
- Overlap: program all 4 positions to 001, overlap_en=1, stream six 001 symbols. Required: pulses after symbols 4, 5 and 6; count=3. Repeat with overlap_en=0 and eight 001 symbols. Required: pulses after symbols 4 and 8 only.
- Bubbles and don't-care: stream 001,101,110,111 with 2-cycle data_valid=0 gaps between symbols. Required: one match. Then write cfg_idx=2 with cfg_care=0 and stream 001,101,000,111. Required: match.
- Config mid-stream: accept 001,101,110, then issue cfg_we (idx 3, 111, care 1) in the same cycle as data_valid with data=111. Required: hist_fill=0, no pulse. Next 111 alone does not match.
- Reset mid-operation and saturation: with CNT_W=2, produce 4 matches. Required: match_count=3 and holding. Then raise rst_n between clock edges. Required: seq_found, match_count and hist_fill read 0 before the next edge; pattern returns to PATTERN_INIT.
